// File: rtl/rr_mux_arbiter_pkg.sv
// rtl/rr_mux_arbiter_pkg.sv - shared constants, state type and round-robin pick function for rr_mux_arbiter
package arb_pkg;

  localparam int NREQ = 4;
  localparam int SELW = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Search last+1 .. last+4 (mod 4); the previous winner is visited last.
  function automatic logic [SELW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                              input logic [SELW-1:0] last);
    logic [SELW-1:0] idx;
    logic            found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = last + SELW'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// rtl/rr_mux_arbiter_if.sv - requester/arbiter bus bundle with master (requesters) and slave (arbiter) modports
interface rr_mux_arbiter_if #(parameter int DW = 2);
  import arb_pkg::*;

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] data_in;
  logic [NREQ-1:0]    gnt;
  logic [SELW-1:0]    sel;
  logic [DW-1:0]      out_data;
  logic               out_valid;

  modport master (
    output req, data_in,
    input  gnt, sel, out_data, out_valid
  );

  modport slave (
    input  req, data_in,
    output gnt, sel, out_data, out_valid
  );

endinterface

// File: rtl/rr_mux_arbiter_mux4_dw.sv
// rtl/rr_mux_arbiter_mux4_dw.sv - combinational 4:1 DW-bit select mux; unknown select yields zero
module mux4_dw
  import arb_pkg::*;
#(
  parameter int DW = 2
) (
  input  logic [SELW-1:0]    sel,
  input  logic [NREQ*DW-1:0] data_in,
  output logic [DW-1:0]      out_data
);

  always_comb begin
    out_data = '0;
    case (sel)
      2'd0:    out_data = data_in[0*DW +: DW];
      2'd1:    out_data = data_in[1*DW +: DW];
      2'd2:    out_data = data_in[2*DW +: DW];
      2'd3:    out_data = data_in[3*DW +: DW];
      default: out_data = '0;
    endcase
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin arbiter owning a 4:1 data mux; ARB_BURST_EN enables grant holding up to MAX_HOLD cycles
module rr_mux_arbiter
  import arb_pkg::*;
#(
  parameter int DW       = 2,
  parameter int MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  rr_mux_arbiter_if.slave bus
);

  if (MAX_HOLD < 1) begin : g_hold_check
    $error("rr_mux_arbiter: MAX_HOLD must be >= 1");
  end

  arb_state_t      state;
  logic [SELW-1:0] last_q;
  logic [SELW-1:0] sel_q;
  logic [NREQ-1:0] gnt_q;
  logic [SELW-1:0] win;
  logic [DW-1:0]   mux_out;

  assign win = rr_pick(bus.req, last_q);

`ifdef ARB_BURST_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_cnt;
  logic          keep;

  // Holder keeps the channel while it still requests and has budget left.
  assign keep = (state == GRANT) && bus.req[last_q] && (hold_cnt < HW'(MAX_HOLD));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt_q  <= '0;
      sel_q  <= '0;
      last_q <= 2'b11;
`ifdef ARB_BURST_EN
      hold_cnt <= '0;
`endif
    end else begin
`ifdef ARB_BURST_EN
      if (keep) begin
        hold_cnt <= hold_cnt + HW'(1);
      end else if (|bus.req) begin
        state    <= GRANT;
        gnt_q    <= NREQ'(1) << win;
        sel_q    <= win;
        last_q   <= win;
        hold_cnt <= HW'(1);
      end else begin
        state    <= IDLE;
        gnt_q    <= '0;
        sel_q    <= '0;
        hold_cnt <= '0;
      end
`else
      if (|bus.req) begin
        state  <= GRANT;
        gnt_q  <= NREQ'(1) << win;
        sel_q  <= win;
        last_q <= win;
      end else begin
        state <= IDLE;
        gnt_q <= '0;
        sel_q <= '0;
      end
`endif
    end
  end

  mux4_dw #(.DW(DW)) u_mux (
    .sel      (sel_q),
    .data_in  (bus.data_in),
    .out_data (mux_out)
  );

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.out_valid = (state == GRANT);
  assign bus.out_data  = bus.out_valid ? mux_out : '0;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - directed table-driven bench for rr_mux_arbiter (default build or ARB_BURST_EN)
module tb_rr_mux_arbiter;

  localparam int DW       = 2;
  localparam int MAX_HOLD = 4;
`ifdef ARB_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef struct {
    logic [3:0] req;
    logic [7:0] data;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [1:0] dat;
    logic       vld;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  rr_mux_arbiter_if #(.DW(DW)) bus ();

  rr_mux_arbiter #(.DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [1:0] mx_sel;
  logic [7:0] mx_data;
  logic [1:0] mx_out;

  mux4_dw #(.DW(DW)) u_mx (
    .sel      (mx_sel),
    .data_in  (mx_data),
    .out_data (mx_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " gnt"}, 32'(bus.gnt), 32'h0);
    check({tag, " sel"}, 32'(bus.sel), 32'h0);
    check({tag, " valid"}, 32'(bus.out_valid), 32'h0);
    check({tag, " data"}, 32'(bus.out_data), 32'h0);
  endtask

  task automatic do_reset(input logic [3:0] req_during);
    rst_n    = 1'b0;
    bus.req  = req_during;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t tbl [8];

  initial begin
    int exp_idx;

    tbl[0] = '{4'b0000, 8'b00_00_00_00, 4'b0000, 2'd0, 2'b00, 1'b0};
    tbl[1] = '{4'b0100, 8'b00_10_00_00, 4'b0100, 2'd2, 2'b10, 1'b1};
    tbl[2] = '{4'b0000, 8'b00_10_00_00, 4'b0000, 2'd0, 2'b00, 1'b0};
    tbl[3] = '{4'b0010, 8'b11_10_01_00, 4'b0010, 2'd1, 2'b01, 1'b1};
`ifdef ARB_BURST_EN
    tbl[4] = '{4'b1010, 8'b11_10_01_00, 4'b0010, 2'd1, 2'b01, 1'b1};
    tbl[5] = '{4'b1010, 8'b11_10_01_00, 4'b0010, 2'd1, 2'b01, 1'b1};
    tbl[6] = '{4'b0001, 8'b11_10_01_10, 4'b0001, 2'd0, 2'b10, 1'b1};
    tbl[7] = '{4'b1111, 8'b11_10_01_10, 4'b0001, 2'd0, 2'b10, 1'b1};
`else
    tbl[4] = '{4'b1010, 8'b11_10_01_00, 4'b1000, 2'd3, 2'b11, 1'b1};
    tbl[5] = '{4'b1010, 8'b11_10_01_00, 4'b0010, 2'd1, 2'b01, 1'b1};
    tbl[6] = '{4'b0001, 8'b11_10_01_10, 4'b0001, 2'd0, 2'b10, 1'b1};
    tbl[7] = '{4'b1111, 8'b11_10_01_10, 4'b0010, 2'd1, 2'b01, 1'b1};
`endif

    rst_n       = 1'b0;
    bus.req     = 4'b0000;
    bus.data_in = 8'h00;
    mx_sel      = 2'd0;
    mx_data     = 8'h00;
    #1;
    check_idle("reset");

    // Full request from reset: rotation 0,1,2,3,0 (burst: each held MAX_HOLD cycles)
    bus.data_in = 8'b11_10_01_00;
    do_reset(4'b1111);
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      #1;
      exp_idx = BURST ? (k / MAX_HOLD) % 4 : k % 4;
      check($sformatf("rot%0d gnt", k), 32'(bus.gnt), 32'(4'b0001 << exp_idx));
      check($sformatf("rot%0d data", k), 32'(bus.out_data), 32'(exp_idx));
    end

    // Asynchronous reset in mid-cycle clears outputs without a clock edge
    #3;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");

    do_reset(4'b0000);
    for (int i = 0; i < 8; i++) begin
      bus.req     = tbl[i].req;
      bus.data_in = tbl[i].data;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d gnt", i), 32'(bus.gnt), 32'(tbl[i].gnt));
      check($sformatf("vec%0d sel", i), 32'(bus.sel), 32'(tbl[i].sel));
      check($sformatf("vec%0d data", i), 32'(bus.out_data), 32'(tbl[i].dat));
      check($sformatf("vec%0d valid", i), 32'(bus.out_valid), 32'(tbl[i].vld));
    end

    // out_data tracks data_in combinationally while granted
    do_reset(4'b0000);
    bus.req     = 4'b0100;
    bus.data_in = 8'b00_10_00_00;
    @(posedge clk);
    #1;
    check("comb gnt", 32'(bus.gnt), 32'h4);
    bus.data_in = 8'b00_01_00_00;
    #1;
    check("comb data", 32'(bus.out_data), 32'h1);
    bus.req = 4'b0000;
    @(posedge clk);
    #1;
    check_idle("drop");

    // Two requesters held: alternate (burst: MAX_HOLD cycles each)
    do_reset(4'b0011);
    bus.data_in = 8'b11_10_01_10;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      #1;
      exp_idx = BURST ? (k / MAX_HOLD) % 2 : k % 2;
      check($sformatf("pair%0d gnt", k), 32'(bus.gnt), 32'(4'b0001 << exp_idx));
      check($sformatf("pair%0d sel", k), 32'(bus.sel), 32'(exp_idx));
    end

    // Standalone mux: unknown select must give zero
    mx_data = 8'b11_10_01_00;
    mx_sel  = 2'bxx;
    #1;
    check("mux selx", 32'(mx_out), 32'h0);
    mx_sel = 2'd2;
    #1;
    check("mux sel2", 32'(mx_out), 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
